// File: rtl/matmul_result_reader_pkg.sv
`default_nettype none
// ============================================================================
//  matmul_result_reader_pkg
//  Shared FSM encoding and C-matrix / flag layout helpers for the reader.
//  Revision: 1.0
// ============================================================================
package matmul_result_reader_pkg;

    localparam int DIM_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    function automatic int calc_max_dim(input int data_w, input int bus_w);
        int d;
        d = (data_w > 0) ? (bus_w / data_w) : 1;
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int elem_offset(input int r, input int c, input int max_dim, input int bus_w);
        return (r * max_dim + c) * bus_w;
    endfunction

    function automatic int flag_index(input int r, input int c, input int max_dim);
        return r + c * max_dim;
    endfunction

    // Dimensions beyond the physical array would index past the snapshot.
    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d, input int max_dim);
        if (int'(d) > max_dim - 1) begin
            return DIM_W'(max_dim - 1);
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_result_reader_if.sv
`default_nettype none
// ============================================================================
//  matmul_result_reader_if
//  Valid/ready element stream carrying one C element with its coordinates.
//  Revision: 1.0
// ============================================================================
interface matmul_result_reader_if #(
    parameter int BUS_WIDTH = 16
);
    logic [BUS_WIDTH-1:0] rd_data_o;
    logic [1:0]           rd_row_o;
    logic [1:0]           rd_col_o;
    logic                 rd_flag_o;
    logic                 rd_last_o;
    logic                 rd_valid_o;
    logic                 rd_ready_i;

    modport master (
        output rd_data_o, rd_row_o, rd_col_o, rd_flag_o, rd_last_o, rd_valid_o,
        input  rd_ready_i
    );

    modport slave (
        input  rd_data_o, rd_row_o, rd_col_o, rd_flag_o, rd_last_o, rd_valid_o,
        output rd_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/matmul_result_reader.sv
`default_nettype none
// ============================================================================
//  matmul_result_reader
//  Snapshots the multiplier result and streams it row-major over valid/ready.
//  Revision: 1.0
// ============================================================================
module matmul_result_reader
    import matmul_result_reader_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUS_WIDTH  = 16,
    localparam int MAX_DIM    = calc_max_dim(DATA_WIDTH, BUS_WIDTH),
    localparam int C_W        = MAX_DIM * MAX_DIM * BUS_WIDTH,
    localparam int F_W        = MAX_DIM * MAX_DIM
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  finish_mul_i,
    input  logic [DIM_W-1:0]      n_dim_i,
    input  logic [DIM_W-1:0]      m_dim_i,
    input  logic [C_W-1:0]        c_matrix_i,
    input  logic [F_W-1:0]        flags_i,
    matmul_result_reader_if.master rd,
    output logic                  finish_write_o,
    output logic                  busy_o,
    output logic                  overflow_any_o
);

    localparam int EIDX_W = (C_W > 1) ? $clog2(C_W) : 1;
    localparam int FIDX_W = (F_W > 1) ? $clog2(F_W) : 1;

    logic [1:0]       state_q,  state_d;
    logic [DIM_W-1:0] row_q,    row_d;
    logic [DIM_W-1:0] col_q,    col_d;
    logic [DIM_W-1:0] n_q,      n_d;
    logic [DIM_W-1:0] m_q,      m_d;
    logic [C_W-1:0]   snap_c_q, snap_c_d;
    logic [F_W-1:0]   snap_f_q, snap_f_d;
    logic             ovf_q,    ovf_d;

    logic [DIM_W-1:0]  n_cap;
    logic [DIM_W-1:0]  m_cap;
    logic [EIDX_W-1:0] elem_idx;
    logic [FIDX_W-1:0] flag_idx;
    logic              valid;

    assign n_cap = clamp_dim(n_dim_i, MAX_DIM);
    assign m_cap = clamp_dim(m_dim_i, MAX_DIM);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        n_d      = n_q;
        m_d      = m_q;
        snap_c_d = snap_c_q;
        snap_f_d = snap_f_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (finish_mul_i) begin
                    snap_c_d = c_matrix_i;
                    snap_f_d = flags_i;
                    n_d      = n_cap;
                    m_d      = m_cap;
                    row_d    = '0;
                    col_d    = '0;
                    ovf_d    = 1'b0;
                    // Only PEs inside the active region contribute to the summary flag.
                    for (int r = 0; r < MAX_DIM; r++) begin
                        for (int c = 0; c < MAX_DIM; c++) begin
                            if (r <= int'(n_cap) && c <= int'(m_cap)) begin
                                ovf_d = ovf_d | flags_i[FIDX_W'(flag_index(r, c, MAX_DIM))];
                            end
                        end
                    end
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (rd.rd_ready_i) begin
                    if (col_q == m_q) begin
                        col_d = '0;
                        if (row_q == n_q) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!finish_mul_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            n_q      <= '0;
            m_q      <= '0;
            snap_c_q <= '0;
            snap_f_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            n_q      <= n_d;
            m_q      <= m_d;
            snap_c_q <= snap_c_d;
            snap_f_q <= snap_f_d;
            ovf_q    <= ovf_d;
        end
    end

    assign elem_idx = EIDX_W'(elem_offset(int'(row_q), int'(col_q), MAX_DIM, BUS_WIDTH));
    assign flag_idx = FIDX_W'(flag_index(int'(row_q), int'(col_q), MAX_DIM));
    assign valid    = (state_q == ST_SEND);

    // Element fields are gated so the bus idles at zero outside SEND.
    assign rd.rd_valid_o  = valid;
    assign rd.rd_data_o   = valid ? snap_c_q[elem_idx +: BUS_WIDTH] : '0;
    assign rd.rd_row_o    = valid ? row_q : '0;
    assign rd.rd_col_o    = valid ? col_q : '0;
    assign rd.rd_flag_o   = valid & snap_f_q[flag_idx];
    assign rd.rd_last_o   = valid & (row_q == n_q) & (col_q == m_q);

    assign finish_write_o = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);
    assign overflow_any_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_result_reader.sv
`default_nettype none
// ============================================================================
//  tb_matmul_result_reader
//  Directed bench for the result reader: full rate, stalls, dims, flags, reset.
//  Revision: 1.0
// ============================================================================
module tb_matmul_result_reader;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        flag;
        logic        last;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        finish;
    logic [1:0]  n_dim;
    logic [1:0]  m_dim;
    logic [63:0] c_mat;
    logic [3:0]  flags;
    logic        ready;
    logic        fw;
    logic        busy;
    logic        ovf;

    int   checks   = 0;
    int   failures = 0;
    int   fw_cyc;
    obs_t xq[$];
    obs_t hq[$];

    matmul_result_reader_if #(.BUS_WIDTH(16)) rd_if ();

    assign rd_if.rd_ready_i = ready;

    matmul_result_reader #(
        .DATA_WIDTH (8),
        .BUS_WIDTH  (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .finish_mul_i   (finish),
        .n_dim_i        (n_dim),
        .m_dim_i        (m_dim),
        .c_matrix_i     (c_mat),
        .flags_i        (flags),
        .rd             (rd_if.master),
        .finish_write_o (fw),
        .busy_o         (busy),
        .overflow_any_o (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_c(input logic [15:0] e00, input logic [15:0] e01,
                                           input logic [15:0] e10, input logic [15:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic obs_t sample_bus();
        obs_t o;
        o.data = rd_if.rd_data_o;
        o.row  = rd_if.rd_row_o;
        o.col  = rd_if.rd_col_o;
        o.flag = rd_if.rd_flag_o;
        o.last = rd_if.rd_last_o;
        return o;
    endfunction

    // Cycle 1 is the first sample after the capture edge; stalls withhold ready
    // while transfer number stall_idx is being offered.
    task automatic drain(input int budget, input int stall_idx, input int stall_len, output int fw_at);
        int stalls = 0;
        int nx     = 0;
        fw_at = -1;
        xq.delete();
        hq.delete();
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (fw) begin
                fw_at = cyc;
                break;
            end
            if (rd_if.rd_valid_o) begin
                if (nx == stall_idx && stalls < stall_len) begin
                    ready = 1'b0;
                    stalls++;
                    hq.push_back(sample_bus());
                end else begin
                    ready = 1'b1;
                    xq.push_back(sample_bus());
                    nx++;
                end
            end else begin
                ready = 1'b1;
            end
            tick();
        end
        ready = 1'b1;
    endtask

    task automatic check_xfers(input string tag, input int cnt, input logic [15:0] ed[4],
                               input int er[4], input int ec[4], input logic ef[4]);
        chk_int({tag, "_count"}, xq.size(), cnt);
        for (int i = 0; i < cnt && i < xq.size(); i++) begin
            chk16($sformatf("%s_data%0d", tag, i), xq[i].data, ed[i]);
            chk_int($sformatf("%s_row%0d", tag, i), int'(xq[i].row), er[i]);
            chk_int($sformatf("%s_col%0d", tag, i), int'(xq[i].col), ec[i]);
            chk1($sformatf("%s_flag%0d", tag, i), xq[i].flag, ef[i]);
            chk1($sformatf("%s_last%0d", tag, i), xq[i].last, (i == cnt - 1));
        end
    endtask

    task automatic go_idle();
        finish = 1'b0;
        tick();
        tick();
        chk1("idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        finish = 1'b0;
        n_dim  = 2'd0;
        m_dim  = 2'd0;
        c_mat  = '0;
        flags  = '0;
        ready  = 1'b1;
        tick();
        tick();
        chk1("rst_valid", rd_if.rd_valid_o, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_fw", fw, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        chk16("rst_data", rd_if.rd_data_o, 16'h0000);
        rst = 1'b0;
        tick();
        chk1("post_rst_busy", busy, 1'b0);

        // 2x2 at full rate; inputs are scrambled right after capture.
        n_dim  = 2'd1;
        m_dim  = 2'd1;
        c_mat  = pack_c(16'h0001, 16'hFFFE, 16'h012C, 16'h0004);
        flags  = 4'b0000;
        finish = 1'b1;
        tick();
        c_mat  = 64'hDEAD_BEEF_CAFE_F00D;
        flags  = 4'b1111;
        drain(20, -1, 0, fw_cyc);
        chk_int("full_fw_cycle", fw_cyc, 5);
        check_xfers("full", 4, '{16'h0001, 16'hFFFE, 16'h012C, 16'h0004},
                    '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{1'b0, 1'b0, 1'b0, 1'b0});
        chk1("full_ovf", ovf, 1'b0);
        tick();
        chk1("fw_one_cycle", fw, 1'b0);

        // Done level held: no recapture while finish stays high.
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("held_busy%0d", i), busy, 1'b1);
            chk1($sformatf("held_valid%0d", i), rd_if.rd_valid_o, 1'b0);
            tick();
        end
        finish = 1'b0;
        c_mat  = pack_c(16'h0005, 16'h0006, 16'h0007, 16'h0008);
        flags  = 4'b0000;
        tick();
        chk1("release_busy", busy, 1'b0);
        finish = 1'b1;
        tick();
        chk1("restart_valid", rd_if.rd_valid_o, 1'b1);
        drain(20, -1, 0, fw_cyc);
        chk_int("restart_fw_cycle", fw_cyc, 5);
        check_xfers("restart", 4, '{16'h0005, 16'h0006, 16'h0007, 16'h0008},
                    '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{1'b0, 1'b0, 1'b0, 1'b0});
        go_idle();

        // Backpressure on element (0,1) for three cycles.
        c_mat  = pack_c(16'h0001, 16'hFFFE, 16'h012C, 16'h0004);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        drain(30, 1, 3, fw_cyc);
        chk_int("bp_fw_cycle", fw_cyc, 8);
        chk_int("bp_stalls", hq.size(), 3);
        foreach (hq[i]) begin
            chk16($sformatf("bp_hold_data%0d", i), hq[i].data, 16'hFFFE);
            chk_int($sformatf("bp_hold_row%0d", i), int'(hq[i].row), 0);
            chk_int($sformatf("bp_hold_col%0d", i), int'(hq[i].col), 1);
            chk1($sformatf("bp_hold_last%0d", i), hq[i].last, 1'b0);
        end
        check_xfers("bp", 4, '{16'h0001, 16'hFFFE, 16'h012C, 16'h0004},
                    '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{1'b0, 1'b0, 1'b0, 1'b0});
        go_idle();

        // Single flag at (1,0) inside a 2x2 region.
        flags  = 4'b0010;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk1("flag_ovf", ovf, 1'b1);
        drain(20, -1, 0, fw_cyc);
        chk_int("flag_fw_cycle", fw_cyc, 5);
        check_xfers("flag", 4, '{16'h0001, 16'hFFFE, 16'h012C, 16'h0004},
                    '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{1'b0, 1'b0, 1'b1, 1'b0});
        go_idle();

        // Partial dims n=0, m=1 with the same flag now outside the region.
        n_dim  = 2'd0;
        m_dim  = 2'd1;
        c_mat  = pack_c(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk1("part_ovf", ovf, 1'b0);
        drain(20, -1, 0, fw_cyc);
        chk_int("part_fw_cycle", fw_cyc, 3);
        check_xfers("part", 2, '{16'h0011, 16'h0022, 16'h0000, 16'h0000},
                    '{0, 0, 0, 0}, '{0, 1, 0, 0}, '{1'b0, 1'b0, 1'b0, 1'b0});
        go_idle();

        // Reset in the middle of a stream.
        n_dim  = 2'd1;
        m_dim  = 2'd1;
        flags  = 4'b1111;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        chk1("pre_rst_valid", rd_if.rd_valid_o, 1'b1);
        chk1("pre_rst_ovf", ovf, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mid_rst_valid", rd_if.rd_valid_o, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_fw", fw, 1'b0);
        chk1("mid_rst_ovf", ovf, 1'b0);
        chk1("mid_rst_last", rd_if.rd_last_o, 1'b0);
        chk16("mid_rst_data", rd_if.rd_data_o, 16'h0000);
        tick();
        tick();
        chk1("rst_hold_fw", fw, 1'b0);
        rst = 1'b0;
        tick();
        chk1("after_rst_busy", busy, 1'b0);
        chk1("after_rst_fw", fw, 1'b0);
        chk1("after_rst_valid", rd_if.rd_valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_result_reader.md
# matmul_result_reader

Drains the result of the systolic matrix multiplier. When the multiplier raises its finish indication, the block snapshots the flattened C matrix and the per-PE overflow flags. It then streams the active (N+1)×(M+1) elements out one per handshake in row-major order over a valid/ready bus. Finally it returns a one-cycle write-complete pulse, which feeds the multiplier's `finish_write_i`.

## Interface
- `DATA_WIDTH`, default 8: operand element width; used only to derive `MAX_DIM`.
- `BUS_WIDTH`, default 16: result element width and output bus width.
- `MAX_DIM`, localparam, `BUS_WIDTH/DATA_WIDTH`: matrix side length.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `finish_mul_i`  in  1  multiplier done; level, may stay high for many cycles.
- `n_dim_i`  in  2  result rows minus 1; sampled at capture.
- `m_dim_i`  in  2  result columns minus 1; sampled at capture.
- `c_matrix_i`  in  `MAX_DIM*MAX_DIM*BUS_WIDTH`  flattened signed C; element (r,c) is at bits `(r*MAX_DIM+c)*BUS_WIDTH +: BUS_WIDTH`.
- `flags_i`  in  `MAX_DIM*MAX_DIM`  PE overflow flags; flag for (r,c) is bit `r + c*MAX_DIM`.
- `rd_data_o`  out  `BUS_WIDTH`  current element.
- `rd_row_o`, `rd_col_o`  out  2 each  coordinates of the current element.
- `rd_flag_o`  out  1  overflow flag of the current element.
- `rd_last_o`  out  1  current element is (n,m).
- `rd_valid_o`  out  1  element offered.
- `rd_ready_i`  in  1  consumer accepts.
- `finish_write_o`  out  1  one-cycle pulse after the last transfer.
- `busy_o`  out  1  high in every state except IDLE.
- `overflow_any_o`  out  1  OR of the captured flags inside the active region.

## Operation
- The FSM has four states: IDLE, SEND, DONE and HOLD.
- **IDLE:**
  - When `finish_mul_i`=1, register `c_matrix_i`, `flags_i`, `n_dim_i` and `m_dim_i` into the snapshot.
  - Set row=col=0 and go to SEND.
- **SEND:**
  - `rd_valid_o`=1. Data, row, col, flag and last are taken from the snapshot.
  - A transfer occurs when `rd_valid_o` and `rd_ready_i` are both high.
  - On a transfer with col<m: col increments.
  - On a transfer with col==m: col returns to 0 and row increments.
  - On a transfer of (n,m): go to DONE.
- **DONE:** `finish_write_o`=1 for exactly this one cycle, then go to HOLD.
- **HOLD:** wait for `finish_mul_i`=0, then go to IDLE. This prevents re-capture while the multiplier still holds its done level.
- Width rules:
  - Elements pass through unmodified as signed `BUS_WIDTH` values. No sign extension or truncation.
  - `overflow_any_o` is the OR of flags for r≤n, c≤m. It is recomputed at each capture and held until the next capture.
- Inputs `c_matrix_i` and `flags_i` are ignored outside the capture cycle. Changes to them during SEND do not affect output.

## Timing
- Reset value of every output is 0, and the state returns to IDLE. Reset mid-stream aborts the transfer and does not issue `finish_write_o`.
- Capture occurs on edge t, where `finish_mul_i` is high in IDLE. `rd_valid_o` is high from t+1.
- With `rd_ready_i` held high, throughput is one element per cycle. (n+1)(m+1) transfers complete at cycles t+1..t+(n+1)(m+1).
- `finish_write_o` is high in the cycle after the last transfer.
- While `rd_valid_o`=1 and `rd_ready_i`=0, `rd_data_o`, `rd_row_o`, `rd_col_o`, `rd_flag_o` and `rd_last_o` stay stable. `rd_valid_o` never drops before a transfer.
- If `finish_mul_i` is already low in HOLD, HOLD lasts one cycle. Total IDLE-to-IDLE time is (n+1)(m+1)+3 cycles minimum.
- All outputs are registered or decoded from registered state only. There is no combinational path from `rd_ready_i` to `rd_valid_o`.

## Structure
- Shared package contents:
  - the FSM state enum;
  - the `MAX_DIM` derivation;
  - an element-offset function (r,c)→bit index;
  - a flag-index function (r,c)→`r+c*MAX_DIM`.
- The multiplier uses the same layout functions for its packing.
- No sub-module is needed: the element/flag selection is an inline indexed part-select on the snapshot.

## Test plan
- **Reset:** assert `rst_i` mid-SEND. All outputs go to 0 immediately, with no `finish_write_o`. After release, `busy_o`=0.
- **2×2 full rate:** n=m=1, C=[[1,-2],[300,4]], ready=1, `finish_mul_i` high at cycle 0.
  - `rd_data_o` is 0x0001, 0xFFFE, 0x012C, 0x0004 on cycles 1–4.
  - `rd_last_o` is high on cycle 4.
  - `finish_write_o` is high on cycle 5 only.
- **Backpressure:** same matrix, `rd_ready_i`=0 for 3 cycles while element (0,1) is offered. 0xFFFE and row/col 0/1 are held, no element is skipped or duplicated, and `finish_write_o` is delayed by 3 cycles.
- **Partial dims:** n=0, m=1. Exactly 2 transfers, (0,0) then (0,1), with last on (0,1). Row 1 is never presented.
- **Flags:**
  - `flags_i`=4'b0010 (r=1, c=0) with n=m=1: `rd_flag_o` is high only on element (1,0), and `overflow_any_o`=1.
  - Same flags with n=0: `overflow_any_o`=0.
- **Held done:**
  - Keep `finish_mul_i` high for 10 cycles after DONE. There is no second capture and `busy_o` stays 1.
  - Drop `finish_mul_i`, then raise it again with new C. A fresh stream starts 2 cycles later.
